// File: rtl/fib_req_seq.sv
// fib_req_seq: accepts a request for n iterations, launches the fib core once,
// waits for it to start and finish (bounded by TIMEOUT cycles), then presents
// the captured result downstream until it is accepted.
module fib_req_seq #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_n,
  output logic             o_core_stb,
  output logic [WIDTH-1:0] o_core_n,
  input  logic             i_core_busy,
  input  logic [WIDTH-1:0] i_core_fib,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_fib,
  output logic [WIDTH-1:0] o_res_n,
  output logic             o_res_err,
  output logic [CNT_W-1:0] o_res_count
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] fib_q, fib_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [1:0]       sync_q;
  logic             run;
  logic             to_hit;

  // The FSM only runs once the reset release has passed through two flops,
  // so the first state change lands well clear of the deassertion edge.
  assign run = ~sync_q[1];

  // to_q counts completed wait cycles; the cycle that would bring it to
  // TIMEOUT is the last one allowed.
  assign to_hit = (to_q >= TO_W'(TIMEOUT - 1));

  // Reset-release synchroniser: asserts immediately, releases after two edges.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  // State, latched request, captured result, timeout and delivery counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      fib_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      fib_q   <= fib_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next-state and handshake outputs; a busy-low capture beats a timeout
  // in the same cycle because the capture branch is tested first.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    fib_d       = fib_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    o_req_ready = 1'b0;
    o_core_stb  = 1'b0;
    o_res_valid = 1'b0;

    case (state_q)
      IDLE: begin
        o_req_ready = run && !i_core_busy;
        if (o_req_ready && i_req_valid) begin
          n_d = i_req_n;
          if (i_req_n != '0) begin
            state_d = ISSUE;
          end else begin
            fib_d   = '0;
            err_d   = 1'b0;
            state_d = RESULT;
          end
        end
      end

      ISSUE: begin
        o_core_stb = 1'b1;
        to_d       = '0;
        state_d    = WAIT_START;
      end

      WAIT_START: begin
        to_d = to_q + TO_W'(1);
        if (to_hit) begin
          fib_d   = '0;
          err_d   = 1'b1;
          state_d = RESULT;
        end else if (i_core_busy) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        to_d = to_q + TO_W'(1);
        if (!i_core_busy) begin
          fib_d   = i_core_fib;
          err_d   = 1'b0;
          state_d = RESULT;
        end else if (to_hit) begin
          fib_d   = '0;
          err_d   = 1'b1;
          state_d = RESULT;
        end
      end

      RESULT: begin
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_core_n    = n_q;
  assign o_res_n     = n_q;
  assign o_res_fib   = fib_q;
  assign o_res_err   = err_q;
  assign o_res_count = cnt_q;

endmodule

// File: tb/tb_fib_req_seq.sv
// tb_fib_req_seq: drives fib_req_seq with directed and random requests
// against a core stub, and checks every cycle against a transaction-level
// model that predicts result timing and value from n, core start delay and
// TIMEOUT.
module tb_fib_req_seq;

  localparam int W  = 32;
  localparam int T  = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_n = '0;
  logic          core_stb;
  logic [W-1:0]  core_n;
  logic          core_busy = 1'b0;
  logic [W-1:0]  core_fib = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_fib;
  logic [W-1:0]  res_n;
  logic          res_err;
  logic [CW-1:0] res_count;

  always #5 clk = ~clk;

  fib_req_seq #(.WIDTH(W), .TIMEOUT(T), .CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_n     (req_n),
    .o_core_stb  (core_stb),
    .o_core_n    (core_n),
    .i_core_busy (core_busy),
    .i_core_fib  (core_fib),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_fib   (res_fib),
    .o_res_n     (res_n),
    .o_res_err   (res_err),
    .o_res_count (res_count)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Model state: one transaction in flight at most.
  bit            m_tx = 1'b0;
  logic [W-1:0]  m_n = '0;
  logic [W-1:0]  m_fib = '0;
  bit            m_err = 1'b0;
  int            m_s = -100;
  int            m_res = 0;
  logic [CW-1:0] m_cnt = '0;
  int            rel_c = -100;
  bit            was_rst = 1'b0;
  int            n_acc = 0;
  int            n_del = 0;

  // Per-transaction observations used by the literal checks.
  int            obs_acc = 0;
  int            obs_vcyc = -1;
  int            obs_vlen = 0;
  int            obs_nstb = 0;
  logic [W-1:0]  obs_cn = '0;
  logic [W-1:0]  obs_fib = '0;
  bit            obs_err = 1'b0;

  // Core stub: busy from stub_d cycles after the strobe for stub_n cycles
  // (stub_d == 0 means it never starts); n+100 on the first idle cycle.
  bit            stub_on = 1'b0;
  int            stub_s = 0;
  int            stub_d = 0;
  logic [W-1:0]  stub_n = '0;
  int            next_d = 1;
  int            cur_stall = 0;
  bit            drv_req = 1'b0;
  logic [W-1:0]  drv_n = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Input driver: stub outputs, request and result-ready, applied 1 time
  // unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      core_busy = stub_on && (stub_d != 0) && (cyc >= stub_s + stub_d) &&
                  (cyc < stub_s + stub_d + int'(stub_n));
      if (stub_on && (stub_d != 0) && (cyc == stub_s + stub_d + int'(stub_n)))
        core_fib = stub_n + 32'd100;
      else
        core_fib = $urandom;
      if (drv_req) begin
        req_valid = 1'b1;
        req_n     = drv_n;
      end else begin
        req_valid = m_tx ? 1'($urandom_range(0, 1)) : 1'b0;
        req_n     = $urandom;
      end
      if (m_tx && (cyc >= m_res))
        res_ready = ((cyc - m_res) >= cur_stall);
      else
        res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Compare and model update, sampled on the falling edge.
  always @(negedge clk) begin : model
    bit exp_ready;
    bit exp_valid;
    int eff;
    int k;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_stb", core_stb, 0);
      chk("rst_core_n", core_n, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_fib", res_fib, 0);
      chk("rst_res_n", res_n, 0);
      chk("rst_err", res_err, 0);
      chk("rst_count", res_count, 0);
      m_tx    = 1'b0;
      m_n     = '0;
      m_cnt   = '0;
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        rel_c   = cyc;
        was_rst = 1'b0;
      end
      exp_ready = !m_tx && !core_busy && (cyc >= rel_c + 3);
      if (cyc == rel_c)
        chk("ready_after_release", req_ready, 0);
      else if (cyc >= rel_c + 3)
        chk("ready", req_ready, exp_ready);
      chk("core_stb", core_stb, m_tx && (cyc == m_s));
      chk("core_n", core_n, m_n);
      exp_valid = m_tx && (cyc >= m_res);
      chk("res_valid", res_valid, exp_valid);
      if (exp_valid) begin
        chk("res_fib", res_fib, m_fib);
        chk("res_n", res_n, m_n);
        chk("res_err", res_err, m_err);
      end
      chk("res_count", res_count, m_cnt);

      if (m_tx) begin
        if (res_valid) begin
          if (obs_vcyc < 0) obs_vcyc = cyc;
          obs_vlen++;
        end
        if (core_stb) begin
          obs_nstb++;
          obs_cn = core_n;
        end
      end
      if (core_stb) begin
        stub_on = 1'b1;
        stub_s  = cyc;
        stub_n  = core_n;
        stub_d  = next_d;
      end

      if (exp_ready && req_valid) begin
        m_tx     = 1'b1;
        m_n      = req_n;
        obs_acc  = cyc;
        obs_vcyc = -1;
        obs_vlen = 0;
        obs_nstb = 0;
        n_acc++;
        if (req_n == '0) begin
          m_s   = -100;
          m_res = cyc + 1;
          m_fib = '0;
          m_err = 1'b0;
        end else begin
          m_s   = cyc + 1;
          eff   = (next_d == 0) ? 1000000 : next_d + int'(req_n);
          m_err = (eff > T);
          k     = m_err ? T : eff;
          m_res = cyc + 2 + k;
          m_fib = m_err ? '0 : req_n + 32'd100;
        end
      end else if (exp_valid && res_ready) begin
        obs_fib = res_fib;
        obs_err = res_err;
        m_tx    = 1'b0;
        m_cnt   = m_cnt + 1'b1;
        n_del++;
      end
    end
  end

  task automatic do_req(input logic [W-1:0] n, input int d, input int stall, input bit wait_del);
    int a0;
    int d0;
    int i;
    i = 0;
    while (stub_on && (stub_d != 0) && (cyc < stub_s + stub_d) && (i < 400)) begin
      @(posedge clk);
      i++;
    end
    next_d    = d;
    cur_stall = stall;
    drv_n     = n;
    a0        = n_acc;
    d0        = n_del;
    drv_req   = 1'b1;
    i = 0;
    while ((n_acc == a0) && (i < 400)) begin
      @(posedge clk);
      i++;
    end
    drv_req = 1'b0;
    chk("accept_within_budget", n_acc != a0, 1);
    if (wait_del) begin
      i = 0;
      while ((n_del == d0) && (i < 400)) begin
        @(posedge clk);
        i++;
      end
      chk("deliver_within_budget", n_del != d0, 1);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", req_ready, 0);
    chk("arst_stb", core_stb, 0);
    chk("arst_core_n", core_n, 0);
    chk("arst_valid", res_valid, 0);
    chk("arst_fib", res_fib, 0);
    chk("arst_res_n", res_n, 0);
    chk("arst_err", res_err, 0);
    chk("arst_count", res_count, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a1;
    int d0;
    int dsel;
    int d;
    logic [W-1:0] n;
    int exp_cnt[5];
    exp_cnt = '{1, 2, 3, 0, 1};

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);

    // Plain request, ready downstream.
    do_req(32'd5, 1, 0, 1'b1);
    chk("v1_latency", obs_vcyc - obs_acc, 8);
    chk("v1_fib", obs_fib, 105);
    chk("v1_err", obs_err, 0);
    chk("v1_nstb", obs_nstb, 1);
    chk("v1_core_n", obs_cn, 5);
    chk("v1_count", res_count, 1);

    // n = 0 short path.
    do_req(32'd0, 1, 0, 1'b1);
    chk("v2_latency", obs_vcyc - obs_acc, 1);
    chk("v2_fib", obs_fib, 0);
    chk("v2_err", obs_err, 0);
    chk("v2_nstb", obs_nstb, 0);
    chk("v2_count", res_count, 2);

    // Downstream stalls 10 cycles.
    do_req(32'd3, 1, 10, 1'b1);
    chk("v3_fib", obs_fib, 103);
    chk("v3_valid_len", obs_vlen, 11);
    chk("v3_count", res_count, 3);

    // Core never starts: timeout.
    do_req(32'd4, 0, 0, 1'b1);
    chk("v4_latency", obs_vcyc - obs_acc, 18);
    chk("v4_err", obs_err, 1);
    chk("v4_fib", obs_fib, 0);

    // Completion on the timeout cycle wins; one cycle later loses.
    do_req(32'd15, 1, 0, 1'b1);
    chk("tie_err", obs_err, 0);
    chk("tie_fib", obs_fib, 115);
    chk("tie_latency", obs_vcyc - obs_acc, 18);
    do_req(32'd16, 1, 0, 1'b1);
    chk("late_err", obs_err, 1);
    chk("late_latency", obs_vcyc - obs_acc, 18);

    // Core starts late and outlives the timeout; next request must wait.
    do_req(32'd20, 10, 0, 1'b1);
    a1 = obs_acc;
    chk("v4b_err", obs_err, 1);
    do_req(32'd1, 1, 0, 1'b1);
    chk("v4b_blocked_until", obs_acc - a1, 31);
    chk("v4b_fib", obs_fib, 101);

    // Reset in the middle of a long core run.
    do_req(32'd20, 1, 0, 1'b0);
    repeat (5) @(posedge clk);
    d0 = n_del;
    do_reset();
    chk("v5_no_delivery", n_del, d0);
    do_req(32'd2, 1, 0, 1'b1);
    chk("v5_fib", obs_fib, 102);
    chk("v5_err", obs_err, 0);
    chk("v5_count", res_count, 1);

    // Counter wrap with a 2-bit counter.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      do_req(32'd1, 1, 0, 1'b1);
      chk("v6_count", res_count, exp_cnt[j]);
    end

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      dsel = $urandom_range(0, 7);
      d = (dsel == 0) ? 0 : (dsel <= 4) ? 1 : (dsel == 5) ? 2 : (dsel == 6) ? 8 : 20;
      n = ($urandom_range(0, 5) == 0) ? 32'd0 : W'($urandom_range(1, 20));
      do_req(n, d, $urandom_range(0, 3), 1'b1);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_req_seq.md
FIB_REQ_SEQ -- requirements
Module: fib_req_seq

Interface
REQ-001 Parameter WIDTH, default 32, data width of n and result; SHALL match the downstream fib core.
REQ-002 Parameter TIMEOUT, default 1024, max cycles allowed from strobe to core completion.
REQ-003 Parameter CNT_W, default 16, width of the delivered-result counter.
REQ-004 Ports SHALL be:
  i_clk  in  1  sole clock, all state on rising edge
  i_reset  in  1  reset, asynchronous, active-high
  i_req_valid  in  1  upstream request valid
  o_req_ready  out  1  request accepted when valid&&ready
  i_req_n  in  WIDTH  requested iteration count
  o_core_stb  out  1  start strobe to fib core
  o_core_n  out  WIDTH  iteration count to fib core
  i_core_busy  in  1  fib core busy
  i_core_fib  in  WIDTH  fib core result
  o_res_valid  out  1  result valid
  i_res_ready  in  1  downstream accepts result when valid&&ready
  o_res_fib  out  WIDTH  captured result
  o_res_n  out  WIDTH  n that produced o_res_fib
  o_res_err  out  1  result is a timeout, o_res_fib=0
  o_res_count  out  CNT_W  results delivered, wraps modulo 2^CNT_W

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT_START, WAIT_DONE, RESULT.
REQ-006 o_req_ready SHALL be 1 only in IDLE with i_core_busy=0; combinational from state and i_core_busy.
REQ-007 On IDLE handshake SHALL latch i_req_n into n register; go ISSUE if n!=0, else RESULT with o_res_fib=0, o_res_err=0, no strobe.
REQ-008 In ISSUE o_core_stb SHALL be 1 for exactly one cycle, o_core_n=latched n; next state WAIT_START.
REQ-009 o_core_stb SHALL be 0 in all other states; o_core_n SHALL hold latched n at all times.
REQ-010 WAIT_START SHALL move to WAIT_DONE on first cycle i_core_busy=1.
REQ-011 In WAIT_DONE, on first cycle i_core_busy=0 the block SHALL capture i_core_fib into o_res_fib, clear o_res_err, go RESULT; later changes of i_core_fib SHALL be ignored.
REQ-012 Timeout counter SHALL clear in ISSUE, increment each cycle in WAIT_START/WAIT_DONE; on reaching TIMEOUT, go RESULT with o_res_fib=0, o_res_err=1.
REQ-013 If busy-low capture and timeout occur in same cycle, capture SHALL win (o_res_err=0).
REQ-014 In RESULT o_res_valid SHALL be 1, o_res_fib/o_res_n/o_res_err stable until handshake.
REQ-015 On RESULT handshake the block SHALL go IDLE and increment o_res_count by 1, wrapping to 0 after 2^CNT_W-1.
REQ-016 i_req_valid/i_req_n SHALL be ignored outside IDLE; i_res_ready SHALL be ignored outside RESULT.
REQ-017 Minimum latency, accept to o_res_valid for n!=0 with core busy the cycle after strobe: accept(IDLE), ISSUE, WAIT_START, WAIT_DONE ... busy-low cycle +1.
REQ-018 n=0 path: o_res_valid SHALL assert the cycle after accept.

Reset
REQ-019 i_reset=1 SHALL asynchronously force IDLE, o_core_stb=0, o_core_n=0, o_res_valid=0, o_res_fib=0, o_res_n=0, o_res_err=0, o_res_count=0, timeout counter=0.
REQ-020 Reset mid-operation SHALL drop any pending result with no handshake; after release, o_req_ready SHALL wait for i_core_busy=0.
REQ-021 Reset release SHALL be synchronised internally so first state change is no earlier than the second rising edge after deassertion.

Verification
Bench core stub: busy from cycle after strobe for n cycles, drives i_core_fib=n+100 while idle.
V-1 Request n=5, i_res_ready=1 -> one stb, o_core_n=5, o_res_fib=105, o_res_n=5, o_res_err=0, o_res_count=1.
V-2 Request n=0 -> no stb, o_res_valid next cycle, o_res_fib=0, o_res_err=0.
V-3 n=3, i_res_ready low 10 cycles -> o_res_valid/fib=103 held 10 cycles, o_req_ready=0 throughout, count increments once.
V-4 TIMEOUT=16, stub never busy -> o_res_err=1, o_res_fib=0 at cycle 16 after strobe; next request blocked until stub idle.
V-5 i_reset pulsed during WAIT_DONE (n=20) -> all outputs 0 immediately; no result delivered; next n=2 yields 102.
V-6 CNT_W=2, five back-to-back n=1 requests -> o_res_count sequence 1,2,3,0,1.
